// File: rtl/semafor_pkg.sv
// Shared definitions for the intersection light controller: state encoding
// and the width of the seconds counter.
package semafor_pkg;

  localparam int SEC_W = 6;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd63;

  typedef enum logic [2:0] {
    S_VERDE     = 3'd0,
    S_GALBEN    = 3'd1,
    S_GARDA_IN  = 3'd2,
    S_PIETONI   = 3'd3,
    S_CLEAR     = 3'd4,
    S_GARDA_OUT = 3'd5
  } stare_t;

endpackage

// File: rtl/divFrecv.sv
// Clock divider producing a one-cycle pulse every DIV_FACTOR_SEC enabled clocks;
// restart forces the count back to zero so a fresh second begins.
module divFrecv #(
  parameter int DIV_FACTOR_SEC = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic pulse_1_sec
);

  localparam int CW = (DIV_FACTOR_SEC > 1) ? $clog2(DIV_FACTOR_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_FACTOR_SEC - 1);

  logic [CW-1:0] cnt;

  assign pulse_1_sec = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/intersectie_ctrl.sv
// Car/pedestrian intersection controller: green until a latched request and
// minimum green, then yellow, all-red guard, pedestrian phase, guard, green.
module intersectie_ctrl
  import semafor_pkg::*;
#(
  parameter int SECUNDE_VERDE_MIN = 10,
  parameter int SECUNDE_GALBEN    = 3,
  parameter int SECUNDE_GARDA     = 2,
  parameter int SECUNDE_TIMEOUT   = 30,
  parameter int DIV_FACTOR_SEC    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       buton_pieton,
  input  logic       pieton_done,
  output logic       masini_verde,
  output logic       masini_galben,
  output logic       masini_rosu,
  output logic       pieton_enable,
  output logic       pieton_clear,
  output logic       cerere_activa,
  output logic       eroare,
  output logic [2:0] stare_dbg
);

  localparam logic [SEC_W-1:0] VERDE_S   = SEC_W'(SECUNDE_VERDE_MIN);
  localparam logic [SEC_W-1:0] GALBEN_S  = SEC_W'(SECUNDE_GALBEN);
  localparam logic [SEC_W-1:0] GARDA_S   = SEC_W'(SECUNDE_GARDA);
  localparam logic [SEC_W-1:0] TIMEOUT_S = SEC_W'(SECUNDE_TIMEOUT);

  stare_t             stare, stare_next;
  logic [SEC_W-1:0]   sec_cnt;
  logic               pulse_1_sec;
  logic               tranzitie;
  logic               timeout_hit;

  assign tranzitie = (stare_next != stare);
  assign stare_dbg = stare;

  divFrecv #(
    .DIV_FACTOR_SEC(DIV_FACTOR_SEC)
  ) DIV_FRECVENTA (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (stare != S_CLEAR),
    .restart    (tranzitie),
    .pulse_1_sec(pulse_1_sec)
  );

  // Pedestrian link is a level handshake: pieton_enable stays high for the whole
  // walk phase, pieton_done is honoured on any edge it is high in that phase,
  // and pieton_clear pulses once afterwards to return the sequencer to idle.
  always_comb begin
    stare_next  = stare;
    timeout_hit = 1'b0;
    case (stare)
      S_VERDE:     if (sec_cnt >= VERDE_S && cerere_activa) stare_next = S_GALBEN;
      S_GALBEN:    if (sec_cnt == GALBEN_S) stare_next = S_GARDA_IN;
      S_GARDA_IN:  if (sec_cnt == GARDA_S) stare_next = S_PIETONI;
      S_PIETONI: begin
        if (pieton_done) begin
          stare_next = S_CLEAR;
        end else if (sec_cnt == TIMEOUT_S) begin
          stare_next  = S_CLEAR;
          timeout_hit = 1'b1;
        end
      end
      S_CLEAR:     stare_next = S_GARDA_OUT;
      S_GARDA_OUT: if (sec_cnt == GARDA_S) stare_next = S_VERDE;
      default:     stare_next = S_GARDA_OUT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stare         <= S_GARDA_OUT;
      sec_cnt       <= '0;
      cerere_activa <= 1'b0;
      eroare        <= 1'b0;
      masini_verde  <= 1'b0;
      masini_galben <= 1'b0;
      masini_rosu   <= 1'b1;
      pieton_enable <= 1'b0;
      pieton_clear  <= 1'b0;
    end else begin
      stare <= stare_next;
      if (tranzitie) begin
        sec_cnt <= '0;
      end else if (pulse_1_sec && sec_cnt != SEC_MAX) begin
        sec_cnt <= sec_cnt + 1'b1;
      end
      // Entering the walk phase consumes the request and beats a same-edge press.
      if (stare_next == S_PIETONI && stare != S_PIETONI) begin
        cerere_activa <= 1'b0;
      end else if (buton_pieton && stare != S_PIETONI) begin
        cerere_activa <= 1'b1;
      end
      eroare        <= eroare | timeout_hit;
      // Lights are registered copies of the decode of the state being entered.
      masini_verde  <= (stare_next == S_VERDE);
      masini_galben <= (stare_next == S_GALBEN);
      masini_rosu   <= (stare_next != S_VERDE) && (stare_next != S_GALBEN);
      pieton_enable <= (stare_next == S_PIETONI);
      pieton_clear  <= (stare_next == S_CLEAR);
    end
  end

endmodule

// File: tb/tb_intersectie_ctrl.sv
// Bench for intersectie_ctrl: phase/elapsed-cycle model compared every cycle,
// plus directed sequences with hand-computed phase lengths.
module tb_intersectie_ctrl;

  localparam int DIV = 2;
  localparam int VMIN = 4;
  localparam int GALBEN = 2;
  localparam int GARDA = 1;
  localparam int TOUT = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic buton_pieton = 1'b0;
  logic pieton_done = 1'b0;
  logic masini_verde, masini_galben, masini_rosu;
  logic pieton_enable, pieton_clear, cerere_activa, eroare;
  logic [2:0] stare_dbg;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  intersectie_ctrl #(
    .SECUNDE_VERDE_MIN(VMIN),
    .SECUNDE_GALBEN   (GALBEN),
    .SECUNDE_GARDA    (GARDA),
    .SECUNDE_TIMEOUT  (TOUT),
    .DIV_FACTOR_SEC   (DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buton_pieton (buton_pieton),
    .pieton_done  (pieton_done),
    .masini_verde (masini_verde),
    .masini_galben(masini_galben),
    .masini_rosu  (masini_rosu),
    .pieton_enable(pieton_enable),
    .pieton_clear (pieton_clear),
    .cerere_activa(cerere_activa),
    .eroare       (eroare),
    .stare_dbg    (stare_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // {verde, galben, rosu, enable, clear, cerere, eroare}
  logic [6:0] out_vec;
  assign out_vec = {masini_verde, masini_galben, masini_rosu, pieton_enable,
                    pieton_clear, cerere_activa, eroare};

  // model: phase plus cycles spent in it; a timed phase of N seconds holds for
  // N*DIV+1 clocks because the decision is taken on the cycle the count reads N
  typedef enum {M_GREEN, M_YELLOW, M_RED_IN, M_WALK, M_CLEAR, M_RED_OUT} m_ph_t;
  m_ph_t m_ph;
  int    m_t;
  bit    m_cer, m_err;

  function automatic int secs_in(input int t);
    return ((t / DIV) > 63) ? 63 : (t / DIV);
  endfunction

  function automatic m_ph_t next_ph(input m_ph_t ph, input int t, input bit cer, input logic done);
    case (ph)
      M_GREEN:   return (secs_in(t) >= VMIN && cer) ? M_YELLOW : M_GREEN;
      M_YELLOW:  return (t == GALBEN * DIV) ? M_RED_IN : M_YELLOW;
      M_RED_IN:  return (t == GARDA * DIV) ? M_WALK : M_RED_IN;
      M_WALK:    return (done || t == TOUT * DIV) ? M_CLEAR : M_WALK;
      M_CLEAR:   return M_RED_OUT;
      default:   return (t == GARDA * DIV) ? M_GREEN : M_RED_OUT;
    endcase
  endfunction

  function automatic logic [6:0] exp_vec(input m_ph_t ph, input bit cer, input bit err);
    return {ph == M_GREEN, ph == M_YELLOW, ph != M_GREEN && ph != M_YELLOW,
            ph == M_WALK, ph == M_CLEAR, cer, err};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph  <= M_RED_OUT;
      m_t   <= 0;
      m_cer <= 1'b0;
      m_err <= 1'b0;
    end else begin
      m_ph_t n;
      n = next_ph(m_ph, m_t, m_cer, pieton_done);
      m_ph <= n;
      m_t  <= (n != m_ph) ? 0 : m_t + 1;
      if (n == M_WALK && m_ph != M_WALK) m_cer <= 1'b0;
      else if (buton_pieton && m_ph != M_WALK) m_cer <= 1'b1;
      if (m_ph == M_WALK && !pieton_done && m_t == TOUT * DIV) m_err <= 1'b1;
    end
  end

  // scoreboard: every cycle the expected output vector is queued and checked
  logic [6:0] exp_q[$];
  always @(negedge clk) begin
    if (cmp_on) begin
      exp_q.push_back(exp_vec(m_ph, m_cer, m_err));
      checks++;
      if (out_vec !== exp_q[0]) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got %b want %b", $time, out_vec, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_vec(input string name, input logic [6:0] exp);
    checks++;
    if (out_vec !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, out_vec, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  // count clock edges until out_vec[idx] reaches 1, bounded by budget
  task automatic wait_bit(input int idx, input int budget, output int n);
    n = 0;
    while (out_vec[idx] !== 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic press(input int n);
    buton_pieton = 1'b1;
    cyc(n);
    buton_pieton = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    cyc(1);
    cmp_on = 1'b1;
    cyc(2);
    check_vec("reset_state", 7'b0010000);
    @(posedge clk); #2; rst_n = 1'b1;
    wait_bit(6, 30, n);
    check_int("guard_after_reset", n, 3);

    cyc(40);
    check_vec("green_hold_no_request", 7'b1000000);

    press(1);
    check_vec("request_latched", 7'b1000010);
    wait_bit(5, 30, n);
    check_int("yellow_after_long_green", n, 1);
    wait_bit(4, 30, n);
    check_int("yellow_len", n, 5);
    wait_bit(3, 30, n);
    check_int("guard_in_len", n, 3);
    check_vec("walk_entered", 7'b0011000);

    press(2);
    check_vec("button_in_walk_ignored", 7'b0011000);
    pieton_done = 1'b1;
    cyc(1);
    pieton_done = 1'b0;
    check_vec("clear_pulse", 7'b0010100);
    cyc(1);
    check_vec("clear_one_cycle", 7'b0010000);
    wait_bit(6, 30, n);
    check_int("guard_out_len", n, 3);
    check_vec("green_no_error", 7'b1000000);

    cyc(2);
    press(1);
    check_vec("request_at_1s", 7'b1000010);
    wait_bit(5, 30, n);
    check_int("green_min_len_rest", n, 6);
    wait_bit(4, 30, n);
    check_int("yellow_len_2", n, 5);
    wait_bit(3, 30, n);
    check_int("guard_in_len_2", n, 3);
    wait_bit(2, 40, n);
    check_int("walk_timeout_len", n, 11);
    check_vec("timeout_clear_error", 7'b0010101);
    cyc(1);
    check_vec("error_sticky", 7'b0010001);

    press(1);
    check_vec("button_in_guard_latched", 7'b0010011);
    wait_bit(6, 30, n);
    check_int("guard_out_len_2", n, 2);
    check_vec("green_pending_request", 7'b1000011);
    wait_bit(5, 30, n);
    check_int("green_min_with_pending", n, 9);

    cyc(2);
    rst_n = 1'b0;
    #1;
    check_vec("reset_in_yellow", 7'b0010000);
    @(posedge clk); #2; rst_n = 1'b1;
    wait_bit(6, 30, n);
    check_int("guard_after_mid_reset", n, 3);
    cyc(3);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
